// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle WIDTH-bit adder, BITS_PER_CYC bits per clock (optional SERIAL_ADDER_SUB_EN adds subtract)

// One full-adder cell. The ripple chain inside serial_adder is built from these cells.
module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder #(
    parameter int WIDTH        = 8,
    parameter int BITS_PER_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int STEPS = WIDTH / BITS_PER_CYC;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    // Reject parameter sets where the chunks would not tile the operand exactly.
    if ((WIDTH < 2) || (BITS_PER_CYC < 1) || ((WIDTH % BITS_PER_CYC) != 0)) begin : g_bad_param
        $error("serial_adder: BITS_PER_CYC must divide WIDTH and WIDTH must be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [WIDTH-1:0]      a_d;
    logic [WIDTH-1:0]      b_d;
    logic [WIDTH-1:0]      acc_d;
    logic [BITS_PER_CYC:0] chain_c;
    logic [BITS_PER_CYC-1:0] chunk_s;
    logic [WIDTH-1:0]      b_load;
    logic                  carry_load;

    // Operand B and the starting carry as they are captured at accept.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    // Ripple chain over the current low chunk of both operand shift registers.
    assign chain_c[0] = carry_q;
    for (genvar i = 0; i < BITS_PER_CYC; i++) begin : g_fa
        serial_adder_fa u_fa (
            .a  (a_q[i]),
            .b  (b_q[i]),
            .ci (chain_c[i]),
            .s  (chunk_s[i]),
            .co (chain_c[i+1])
        );
    end

    // Operands shift right so the next chunk sits at bit 0; results enter from the MSB side,
    // so after STEPS chunks the first chunk has landed at the bottom of the accumulator.
    assign a_d   = a_q >> BITS_PER_CYC;
    assign b_d   = b_q >> BITS_PER_CYC;
    assign acc_d = WIDTH'({chunk_s, acc_q} >> BITS_PER_CYC);

    // Control FSM with registered handshake outputs; result registers only change on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b_load;
                        carry_q    <= carry_load;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    acc_q   <= acc_d;
                    carry_q <= chain_c[BITS_PER_CYC];
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        sum_q       <= acc_d;
                        cout_q      <= chain_c[BITS_PER_CYC];
                        // The final chunk holds the MSB, so its top internal carry is the carry into bit WIDTH-1.
                        ovf_q       <= chain_c[BITS_PER_CYC-1] ^ chain_c[BITS_PER_CYC];
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at 1 and 4 bits per cycle

module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid, in_ready, cin, out_valid, out_ready, cout, overflow;
    logic [7:0] a, b, sum;
    logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, overflow4;
    logic [7:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub, sub4;
`endif

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    exp_t sb[$];
    exp_t sb4[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .BITS_PER_CYC(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    serial_adder #(.WIDTH(8), .BITS_PER_CYC(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub4),
`endif
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4),
        .overflow  (overflow4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: 9-bit integer add; signed overflow from operand/result sign bits.
    function automatic exp_t model(input logic [7:0] ta, input logic [7:0] tb_v,
                                   input logic tc, input logic ts);
        exp_t       r;
        logic [7:0] bb;
        logic       ci;
        logic [8:0] full;
        bb   = ts ? ~tb_v : tb_v;
        ci   = ts ? 1'b1 : tc;
        full = {1'b0, ta} + {1'b0, bb} + {8'd0, ci};
        r.s  = full[7:0];
        r.c  = full[8];
        r.o  = (ta[7] == bb[7]) && (full[7] != ta[7]);
        return r;
    endfunction

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input logic ts, input int hold);
        int   lat;
        exp_t e;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        a = ta; b = tb_v; cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
        sub = ts;
`endif
        in_valid = 1'b1;
        sb.push_back(model(ta, tb_v, tc, ts));
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            check("run_in_ready", 32'(in_ready), 32'd0);
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            in_valid = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("latency", 32'(lat), 32'd8);
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        check("sum", 32'(sum), 32'(e.s));
        check("cout", 32'(cout), 32'(e.c));
        check("overflow", 32'(overflow), 32'(e.o));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_sum", 32'(sum), 32'(e.s));
            check("hold_cout", 32'(cout), 32'(e.c));
            check("hold_ovf", 32'(overflow), 32'(e.o));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("ret_in_ready", 32'(in_ready), 32'd1);
        check("ret_out_valid", 32'(out_valid), 32'd0);
        check("ret_sum_held", 32'(sum), 32'(e.s));
    endtask

    task automatic run_op4(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc);
        int   lat;
        exp_t e;
        @(negedge clk);
        check("idle_in_ready4", 32'(in_ready4), 32'd1);
        a4 = ta; b4 = tb_v; cin4 = tc; in_valid4 = 1'b1;
        sb4.push_back(model(ta, tb_v, tc, 1'b0));
        @(negedge clk);
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency4", 32'(lat), 32'd2);
        if (sb4.size() == 0) begin
            check("sb4_underflow", 32'(sb4.size()), 32'd1);
            e = '0;
        end else begin
            e = sb4.pop_front();
        end
        check("sum4", 32'(sum4), 32'(e.s));
        check("cout4", 32'(cout4), 32'(e.c));
        check("overflow4", 32'(overflow4), 32'(e.o));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; cin4 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0; sub4 = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_in_ready4", 32'(in_ready4), 32'd1);
        rst_n = 1'b1;

        run_op(8'h5A, 8'h33, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h00, 1'b1, 1'b0, 0);
        run_op(8'hC3, 8'h7E, 1'b1, 1'b0, 5);
        for (int k = 0; k < 6; k++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, int'($urandom_range(0, 2)));
        end
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 0);

        // Abort three cycles into RUN; the aborted operation never produces a result.
        @(negedge clk);
        a = 8'h77; b = 8'h11; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h01, 8'h02, 1'b0, 1'b0, 0);

        run_op4(8'h7F, 8'h01, 1'b0);
        run_op4(8'hA5, 8'h5A, 1'b1);
        run_op4(8'h3C, 8'h4B, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h20, 1'b0, 1'b1, 0);
        run_op(8'h80, 8'h01, 1'b1, 1'b1, 2);
        run_op(8'h33, 8'h11, 1'b1, 1'b0, 0);
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        check("sb4_empty", 32'(sb4.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
